fsm_control_transaccion: RTL



---
 rtl/fsm_control_transaccion.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fsm_control_transaccion.sv
// ----------------------------------------------------------------------------
// fsm_control_transaccion
//
// Main control state machine for the transaction layer. It walks the layer
// through RESET -> INIT (threshold configuration) -> IDLE <-> ACTIVE. It drives
// the almost-full and almost-empty thresholds to every FIFO, and it enables the
// arbiter only while at least one FIFO holds data. Any FIFO error, or an
// invalid threshold pair, freezes the layer in ERROR until reset_L is asserted.
//
// Ports
//   clk           : single clock, rising edge
//   reset_L       : asynchronous active-low reset
//   init          : request to enter or stay in configuration
//   umbral_af_in  : almost-full threshold to load while in INIT
//   umbral_ae_in  : almost-empty threshold to load while in INIT
//   fifo_empty    : per-FIFO empty flags
//   fifo_error    : per-FIFO overflow/underflow pulses
//   estado        : one-hot state (RESET, INIT, IDLE, ACTIVE, ERROR)
//   umbral_af     : almost-full threshold driven to all FIFOs
//   umbral_ae     : almost-empty threshold driven to all FIFOs
//   arb_enable    : arbiter may pop/push (high only in ACTIVE)
//   idle          : layer quiescent (high only in IDLE)
//   error_out     : sticky mask of FIFOs that reported an error
//   cfg_error     : sticky flag, invalid threshold configuration seen
// ----------------------------------------------------------------------------
module fsm_control_transaccion #(
    parameter int N_FIFOS  = 8,
    parameter int UMBRAL_W = 3
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                init,
    input  logic [UMBRAL_W-1:0] umbral_af_in,
    input  logic [UMBRAL_W-1:0] umbral_ae_in,
    input  logic [N_FIFOS-1:0]  fifo_empty,
    input  logic [N_FIFOS-1:0]  fifo_error,
    output logic [4:0]          estado,
    output logic [UMBRAL_W-1:0] umbral_af,
    output logic [UMBRAL_W-1:0] umbral_ae,
    output logic                arb_enable,
    output logic                idle,
    output logic [N_FIFOS-1:0]  error_out,
    output logic                cfg_error
);

    // The encoding is the externally visible estado value, so the state
    // register drives the port directly with no decode.
    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_e;

    state_e              state_q, state_d;
    logic [UMBRAL_W-1:0] af_q, af_d;
    logic [UMBRAL_W-1:0] ae_q, ae_d;
    logic [N_FIFOS-1:0]  err_q, err_d;
    logic                cfg_err_q, cfg_err_d;
    logic                arb_q;
    logic                idle_q;

    logic any_error;
    logic all_empty;
    logic cfg_valid;

    assign any_error = |fifo_error;
    assign all_empty = &fifo_empty;
    // Validity is judged on the thresholds already loaded, i.e. the values
    // currently being driven to the FIFOs.
    assign cfg_valid = (af_q != '0) && (ae_q < af_q);

    // ------------------------------------------------------------------------
    // Next-state logic. Branch order inside each state encodes the priority
    // error > init > empty.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        af_d      = af_q;
        ae_d      = ae_q;
        cfg_err_d = cfg_err_q;
        // Error flags are ignored only in RESET; everywhere else, ERROR
        // included, new pulses accumulate into the sticky mask.
        err_d     = (state_q == ST_RESET) ? err_q : (err_q | fifo_error);

        unique case (state_q)
            ST_RESET: begin
                state_d = ST_INIT;
            end

            ST_INIT: begin
                if (any_error) begin
                    state_d = ST_ERROR;
                end else if (init) begin
                    af_d = umbral_af_in;
                    ae_d = umbral_ae_in;
                end else if (cfg_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_ERROR;
                    cfg_err_d = 1'b1;
                end
            end

            ST_IDLE: begin
                if (any_error) begin
                    state_d = ST_ERROR;
                end else if (init) begin
                    state_d = ST_INIT;
                end else if (!all_empty) begin
                    state_d = ST_ACTIVE;
                end
            end

            ST_ACTIVE: begin
                if (any_error) begin
                    state_d = ST_ERROR;
                end else if (init) begin
                    state_d = ST_INIT;
                end else if (all_empty) begin
                    state_d = ST_IDLE;
                end
            end

            ST_ERROR: begin
                state_d = ST_ERROR;
            end

            // A corrupted encoding is treated like a fault: park in ERROR.
            default: begin
                state_d = ST_ERROR;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and registered Moore outputs. arb_enable/idle are decoded from
    // state_d so they switch on the same edge as estado.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= ST_RESET;
            af_q      <= '0;
            ae_q      <= '0;
            err_q     <= '0;
            cfg_err_q <= 1'b0;
            arb_q     <= 1'b0;
            idle_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values, independent of statement order.
            state_q   <= state_d;
            af_q      <= af_d;
            ae_q      <= ae_d;
            err_q     <= err_d;
            cfg_err_q <= cfg_err_d;
            arb_q     <= (state_d == ST_ACTIVE);
            idle_q    <= (state_d == ST_IDLE);
        end
    end

    assign estado     = state_q;
    assign umbral_af  = af_q;
    assign umbral_ae  = ae_q;
    assign arb_enable = arb_q;
    assign idle       = idle_q;
    assign error_out  = err_q;
    assign cfg_error  = cfg_err_q;

endmodule
